alu_seq: RTL and testbench

Parametrised, handshaked ALU that succeeds the 16-bit combinational ALU. It is generalised to WIDTH bits and adds unsigned compare, shifts, a carry flag and an illegal-opcode flag. An optional iterative multiplier takes WIDTH cycles. The block sits between the decode stage and writeback, with a valid/ready interface on both sides and a registered output stage.

---
 rtl/alu_seq_pkg.sv | 27 ++
 rtl/alu_seq_if.sv | 27 ++
 rtl/alu_mul_iter.sv | 48 ++++
 rtl/alu_seq.sv | 163 ++++++++++++++++
 tb/tb_alu_seq.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state type and opcode legality check for alu_seq.
// Opcode 1010 (MUL) is legal only when ALU_MUL_EN is defined.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;

  typedef enum logic [0:0] {IDLE, MUL_BUSY} state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
`ifdef ALU_MUL_EN
    return op <= OP_MUL;
`else
    return op <= OP_SRA;
`endif
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between decode, alu_seq and writeback.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_control;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             carry;
  logic             err;

  modport master (
    output in_valid, a, b, alu_control, out_ready,
    input  in_ready, out_valid, result, zero, overflow, carry, err
  );

  modport slave (
    input  in_valid, a, b, alu_control, out_ready,
    output in_ready, out_valid, result, zero, overflow, carry, err
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per step, WIDTH steps.
// product/ovf are valid combinationally in the cycle done is high.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             ovf
);
  localparam int unsigned CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q, mcand_q, acc_next;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      count_q;

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      count_q  <= '0;
    end else if (step) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      count_q  <= count_q + 1'b1;
    end
  end

  // The last step's partial sum goes straight to the result registers.
  assign done    = step && (count_q == CW'(WIDTH - 1));
  assign product = acc_next[WIDTH-1:0];
  assign ovf     = |acc_next[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU with registered result stage.
// Define ALU_MUL_EN to build the iterative multiplier (opcode 1010); otherwise MUL is illegal.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);
  localparam int unsigned MSB = WIDTH - 1;

  if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("alu_seq: WIDTH must be a power of 2 and at least 4");
  end

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, carry_q, carry_d, err_q, err_d;

  logic             in_ready, accept, is_mul, mul_start, mul_step, mul_done, mul_ovf;
  logic [WIDTH-1:0] mul_product;

  logic [WIDTH-1:0]   op_a, op_b, op_res;
  logic               op_ovf, op_carry, op_err;
  logic [WIDTH:0]     sum_c, diff_c;
  logic [SHAMT_W-1:0] shamt;

  assign op_a   = bus.a;
  assign op_b   = bus.b;
  assign shamt  = op_b[SHAMT_W-1:0];
  assign sum_c  = {1'b0, op_a} + {1'b0, op_b};
  // a + ~b + 1: bit WIDTH is the NOT-borrow carry.
  assign diff_c = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    op_res   = '0;
    op_ovf   = 1'b0;
    op_carry = 1'b0;
    op_err   = !is_legal_op(bus.alu_control);
    case (bus.alu_control)
      OP_ADD: begin
        op_res   = sum_c[MSB:0];
        op_carry = sum_c[WIDTH];
        op_ovf   = (op_a[MSB] == op_b[MSB]) && (sum_c[MSB] != op_a[MSB]);
      end
      OP_SUB: begin
        op_res   = diff_c[MSB:0];
        op_carry = diff_c[WIDTH];
        op_ovf   = (op_a[MSB] != op_b[MSB]) && (diff_c[MSB] != op_a[MSB]);
      end
      OP_AND:  op_res = op_a & op_b;
      OP_OR:   op_res = op_a | op_b;
      OP_XOR:  op_res = op_a ^ op_b;
      OP_SLT:  op_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU: op_res = {{(WIDTH-1){1'b0}}, op_a < op_b};
      OP_SLL:  op_res = op_a << shamt;
      OP_SRL:  op_res = op_a >> shamt;
      OP_SRA:  op_res = $signed(op_a) >>> shamt;
      default: op_res = '0;
    endcase
  end

  assign in_ready = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign mul_step = (state_q == MUL_BUSY);

`ifdef ALU_MUL_EN
  assign is_mul = (bus.alu_control == OP_MUL);

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .step   (mul_step),
    .a      (op_a),
    .b      (op_b),
    .done   (mul_done),
    .product(mul_product),
    .ovf    (mul_ovf)
  );
`else
  assign is_mul      = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
  assign mul_ovf     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    carry_d     = carry_q;
    err_d       = err_q;
    mul_start   = 1'b0;
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            mul_start = 1'b1;
            state_d   = MUL_BUSY;
          end else begin
            out_valid_d = 1'b1;
            result_d    = op_res;
            zero_d      = (op_res == '0);
            ovf_d       = op_ovf;
            carry_d     = op_carry;
            err_d       = op_err;
          end
        end
      end
      MUL_BUSY: begin
        if (mul_done) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          result_d    = mul_product;
          zero_d      = (mul_product == '0);
          ovf_d       = mul_ovf;
          carry_d     = 1'b0;
          err_d       = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      carry_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      carry_q     <= carry_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.carry     = carry_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=16); follows ALU_MUL_EN like the design.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int unsigned W = 16;

  typedef struct packed {
    logic [W-1:0] res;
    logic         zero;
    logic         ovf;
    logic         carry;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(
    .WIDTH(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   rand_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model written in wide integer arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint ua, ub, sa, sb, r, top, maxs, mins;
    int     sh;
    e    = '0;
    top  = longint'(1) << W;
    maxs = (top >> 1) - 1;
    mins = -(top >> 1);
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    sh   = int'(ub % W);
    r    = 0;
    case (op)
      4'd0: begin
        r = ua + ub;
        e.carry = (r >= top);
        e.ovf = (sa + sb > maxs) || (sa + sb < mins);
      end
      4'd1: begin
        r = ua - ub;
        e.carry = (ua >= ub);
        e.ovf = (sa - sb > maxs) || (sa - sb < mins);
      end
      4'd2: r = ua & ub;
      4'd3: r = ua | ub;
      4'd4: r = ua ^ ub;
      4'd5: r = (sa < sb) ? 1 : 0;
      4'd6: r = (ua < ub) ? 1 : 0;
      4'd7: r = ua << sh;
      4'd8: r = ua >> sh;
      4'd9: r = sa >>> sh;
`ifdef ALU_MUL_EN
      4'd10: begin
        r = ua * ub;
        e.ovf = (r >= top);
      end
`endif
      default: begin
        r = 0;
        e.err = 1'b1;
      end
    endcase
    e.res  = r[W-1:0];
    e.zero = (e.res == '0);
    return e;
  endfunction

  // Every consumed result is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out", {31'b0, bus.out_valid}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_res", {16'b0, bus.result}, {16'b0, mon_e.res});
        check("sb_zero", {31'b0, bus.zero}, {31'b0, mon_e.zero});
        check("sb_ovf", {31'b0, bus.overflow}, {31'b0, mon_e.ovf});
        check("sb_carry", {31'b0, bus.carry}, {31'b0, mon_e.carry});
        check("sb_err", {31'b0, bus.err}, {31'b0, mon_e.err});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    #1;
  endtask

  // Returns just after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    bus.in_valid    = 1'b1;
    bus.alu_control = op;
    bus.a           = a;
    bus.b           = b;
    #1;
    while (!bus.in_ready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) check("accept_timeout", {31'b0, bus.in_ready}, 32'd1);
    else sb_q.push_back(model(op, a, b));
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input exp_t e);
    send(op, a, b);
    check({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
    check({tag, "_res"}, {16'b0, bus.result}, {16'b0, e.res});
    check({tag, "_zero"}, {31'b0, bus.zero}, {31'b0, e.zero});
    check({tag, "_ovf"}, {31'b0, bus.overflow}, {31'b0, e.ovf});
    check({tag, "_carry"}, {31'b0, bus.carry}, {31'b0, e.carry});
    check({tag, "_err"}, {31'b0, bus.err}, {31'b0, e.err});
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || bus.out_valid) && n < 500) begin
      step();
      n++;
    end
    check("drain", sb_q.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd0);
    check({tag, "_res"}, {16'b0, bus.result}, 32'd0);
    check({tag, "_flags"}, {28'b0, bus.zero, bus.overflow, bus.carry, bus.err}, 32'd0);
  endtask

  initial begin
    exp_t e;
    int   n, low;
    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.alu_control = '0;
    bus.out_ready   = 1'b1;
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();
    check("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);

    // Directed vectors: {res, zero, ovf, carry, err}
    directed("add_ovf", OP_ADD, 16'h7FFF, 16'h0001, {16'h8000, 1'b0, 1'b1, 1'b0, 1'b0});
    directed("sub_eq", OP_SUB, 16'hABCD, 16'hABCD, {16'h0000, 1'b1, 1'b0, 1'b1, 1'b0});
    directed("slt", OP_SLT, 16'hFFFF, 16'h0001, {16'h0001, 1'b0, 1'b0, 1'b0, 1'b0});
    directed("sltu", OP_SLTU, 16'hFFFF, 16'h0001, {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
    directed("sra", OP_SRA, 16'h8000, 16'h0004, {16'hF800, 1'b0, 1'b0, 1'b0, 1'b0});
    directed("srl", OP_SRL, 16'h8000, 16'h0014, {16'h0800, 1'b0, 1'b0, 1'b0, 1'b0});
    directed("illegal", 4'b1111, 16'h1234, 16'h5678, {16'h0000, 1'b1, 1'b0, 1'b0, 1'b1});
    drain();

`ifdef ALU_MUL_EN
    send(OP_MUL, 16'h0012, 16'h0034);
    n = 0;
    low = 0;
    while (!bus.out_valid && n < 100) begin
      if (!bus.in_ready) low++;
      step();
      n++;
    end
    check("mul_latency", n, W);
    check("mul_busy_cycles", low, W);
    check("mul_res", {16'b0, bus.result}, 32'h03A8);
    check("mul_ovf", {31'b0, bus.overflow}, 32'd0);
    drain();
    send(OP_MUL, 16'h0100, 16'h0100);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      step();
      n++;
    end
    check("mul2_res", {16'b0, bus.result}, 32'h0000);
    check("mul2_flags", {29'b0, bus.overflow, bus.zero, bus.err}, 32'b110);
    drain();
`else
    directed("mul_illegal", OP_MUL, 16'h0012, 16'h0034, {16'h0000, 1'b1, 1'b0, 1'b0, 1'b1});
    drain();
`endif

    // Backpressure: result held, next op stalls until out_ready rises.
    bus.out_ready = 1'b0;
    send(OP_ADD, 16'h1234, 16'h5678);
    bus.alu_control = OP_XOR;
    bus.a           = 16'hF0F0;
    bus.b           = 16'h0FF0;
    bus.in_valid    = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
      check("bp_hold_res", {16'b0, bus.result}, 32'h68AC);
      check("bp_hold_valid", {31'b0, bus.out_valid}, 32'd1);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'b0, bus.in_ready}, 32'd1);
    sb_q.push_back(model(OP_XOR, 16'hF0F0, 16'h0FF0));
    step();
    check("bp_next_valid", {31'b0, bus.out_valid}, 32'd1);
    check("bp_next_res", {16'b0, bus.result}, 32'hFF00);
    for (int i = 0; i < 4; i++) begin
      bus.alu_control = 4'(i);
      bus.a = 16'(16'h1111 * (i + 1));
      bus.b = 16'(16'h0F0F + i);
      #1;
      check("b2b_ready", {31'b0, bus.in_ready}, 32'd1);
      e = model(4'(i), bus.a, bus.b);
      sb_q.push_back(e);
      step();
      check("b2b_valid", {31'b0, bus.out_valid}, 32'd1);
      check("b2b_res", {16'b0, bus.result}, {16'b0, e.res});
    end
    bus.in_valid = 1'b0;
    drain();

    // Reset with a held result drops it.
    bus.out_ready = 1'b0;
    send(OP_ADD, 16'hFFFF, 16'h0001);
    rst = 1'b1;
    step();
    check_reset_outputs("rst_held");
    sb_q.delete();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    step();

`ifdef ALU_MUL_EN
    send(OP_MUL, 16'h1234, 16'h0003);
    repeat (4) step();
    rst = 1'b1;
    step();
    check_reset_outputs("rst_mul");
    sb_q.delete();
    rst = 1'b0;
    step();
    send(OP_ADD, 16'h0001, 16'h0001);
    check("post_rst_valid", {31'b0, bus.out_valid}, 32'd1);
    check("post_rst_res", {16'b0, bus.result}, 32'h0002);
    repeat (2 * W) step();
    check("no_stale", {31'b0, bus.out_valid}, 32'd0);
`endif

    // Random mix with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
    end
    rand_ready = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
